// File: rtl/seq_shift_unit.sv
`default_nettype none
// ============================================================================
//  Module   : seq_shift_unit
//  Purpose  : Multi-cycle shifter for the ALU datapath. Loads a word and
//             applies LSL / LSR / ASR / ROR one bit position per clock for a
//             programmable number of steps, then reports the result and
//             carry / overflow / zero flags with a one-cycle done pulse.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Parameters
//    WIDTH    data word width (>= 2)
//    SHAMT_W  width of the shift-amount field
//  Ports
//    clk        in   clock, all state on rising edge
//    reset_n    in   asynchronous active-low reset
//    start      in   request, sampled only in IDLE or DONE
//    mode       in   00 LSL, 01 LSR, 10 ASR, 11 ROR
//    amount     in   number of single-bit shifts (0 .. 2^SHAMT_W-1)
//    data_in    in   operand
//    busy       out  high while shifting
//    done       out  one-cycle pulse, result/flags valid
//    result     out  shifted word, held until next accepted start
//    carry_out  out  last bit shifted/rotated out, 0 if amount = 0
//    overflow   out  LSL only: sign bit changed at any step
//    zero       out  result == 0
// ============================================================================
module seq_shift_unit #(
  parameter int WIDTH   = 16,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [1:0]         mode,
  input  logic [SHAMT_W-1:0] amount,
  input  logic [WIDTH-1:0]   data_in,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   result,
  output logic               carry_out,
  output logic               overflow,
  output logic               zero
);

  // --------------------------------------------------------------------------
  // State encoding
  // --------------------------------------------------------------------------
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic [1:0] M_LSL = 2'b00;
  localparam logic [1:0] M_LSR = 2'b01;
  localparam logic [1:0] M_ASR = 2'b10;
  localparam logic [1:0] M_ROR = 2'b11;

  localparam logic [SHAMT_W-1:0] c_cnt_one = SHAMT_W'(1);

  // --------------------------------------------------------------------------
  // Registers and next-state values
  // --------------------------------------------------------------------------
  logic [1:0]         state_q,  state_d;
  logic [1:0]         mode_q,   mode_d;
  logic [SHAMT_W-1:0] cnt_q,    cnt_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               carry_q,  carry_d;
  logic               ovf_q,    ovf_d;

  logic               w_accept;
  logic [WIDTH-1:0]   w_shifted;
  logic               w_shift_carry;
  logic               w_sign_change;

  // A new request is taken only when the unit is not shifting; DONE counts
  // as available so that a held start runs operations back-to-back.
  assign w_accept = start && ((state_q == S_IDLE) || (state_q == S_DONE));

  // --------------------------------------------------------------------------
  // One-step shift datapath, driven by the latched mode
  // --------------------------------------------------------------------------
  always_comb begin
    w_shifted     = result_q;
    w_shift_carry = 1'b0;
    case (mode_q)
      M_LSL: begin
        w_shifted     = {result_q[WIDTH-2:0], 1'b0};
        w_shift_carry = result_q[WIDTH-1];
      end
      M_LSR: begin
        w_shifted     = {1'b0, result_q[WIDTH-1:1]};
        w_shift_carry = result_q[0];
      end
      M_ASR: begin
        w_shifted     = {result_q[WIDTH-1], result_q[WIDTH-1:1]};
        w_shift_carry = result_q[0];
      end
      M_ROR: begin
        w_shifted     = {result_q[0], result_q[WIDTH-1:1]};
        w_shift_carry = result_q[0];
      end
      default: begin
        w_shifted     = result_q;
        w_shift_carry = 1'b0;
      end
    endcase
  end

  // The sign bit changes on this LSL step exactly when the two top bits
  // differ before the shift.
  assign w_sign_change = result_q[WIDTH-1] ^ result_q[WIDTH-2];

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    carry_d  = carry_q;
    ovf_d    = ovf_q;

    if (w_accept) begin
      result_d = data_in;
      mode_d   = mode;
      cnt_d    = amount;
      carry_d  = 1'b0;
      ovf_d    = 1'b0;
      state_d  = (amount != '0) ? S_SHIFT : S_DONE;
    end else begin
      case (state_q)
        S_SHIFT: begin
          result_d = w_shifted;
          carry_d  = w_shift_carry;
          if (mode_q == M_LSL) begin
            ovf_d = ovf_q | w_sign_change;
          end
          cnt_d = cnt_q - c_cnt_one;
          // Last step: counter is about to go 1 -> 0.
          if (cnt_q == c_cnt_one) begin
            state_d = S_DONE;
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
        end
        S_IDLE: begin
          state_d = S_IDLE;
        end
        default: begin
          // Unreachable encoding: recover to IDLE.
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      mode_q   <= M_LSL;
      cnt_q    <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      ovf_q    <= ovf_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs: status decoded from the state register, so busy and done are
  // mutually exclusive and glitch-free with respect to inputs.
  // --------------------------------------------------------------------------
  assign busy      = (state_q == S_SHIFT);
  assign done      = (state_q == S_DONE);
  assign result    = result_q;
  assign carry_out = carry_q;
  assign overflow  = ovf_q;
  assign zero      = (result_q == '0);

endmodule
`default_nettype wire

// File: tb/tb_seq_shift_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seq_shift_unit
//  Purpose  : Self-checking bench for seq_shift_unit. Stimulus pushes the
//             expected outcome of each accepted operation into a queue; a
//             monitor pops and compares whenever done is presented.
//  Revision : 1.0  initial release
// ============================================================================
module tb_seq_shift_unit;

  localparam int W  = 16;
  localparam int SW = 5;

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic          start = 1'b0;
  logic [1:0]    mode = 2'b00;
  logic [SW-1:0] amount = '0;
  logic [W-1:0]  data_in = '0;
  logic          busy, done, carry_out, overflow, zero;
  logic [W-1:0]  result;

  seq_shift_unit #(.WIDTH(W), .SHAMT_W(SW)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .mode      (mode),
    .amount    (amount),
    .data_in   (data_in),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .carry_out (carry_out),
    .overflow  (overflow),
    .zero      (zero)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] res;
    logic         c;
    logic         v;
    logic         z;
    int           amt;
    int           cyc;
  } exp_t;

  exp_t exp_q[$];
  exp_t last_e;
  exp_t mon_e;
  bit   have_last = 0;
  int   busy_run  = 0;
  int   total     = 0;
  int   bad       = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference model: closed-form result of shifting 'a' positions.
  function automatic exp_t model(input logic [1:0] m, input int a, input logic [W-1:0] d);
    exp_t e;
    logic [2*W-1:0] dd;
    logic [63:0]    x, top;
    e.c   = 1'b0;
    e.v   = 1'b0;
    e.res = d;
    case (m)
      2'b00: begin
        e.res = (a >= W) ? '0 : W'(d << a);
        e.c   = (a == 0) ? 1'b0 : (a <= W) ? d[W-a] : 1'b0;
        // Sign changes at some step iff the top a+1 bits of d (zeros below
        // bit 0) are not all equal.
        x     = {d, 48'd0};
        top   = x >> (63 - a);
        e.v   = !((top == 64'd0) || (top == ((64'd1 << (a + 1)) - 64'd1)));
      end
      2'b01: begin
        e.res = (a >= W) ? '0 : W'(d >> a);
        e.c   = (a == 0) ? 1'b0 : (a <= W) ? d[a-1] : 1'b0;
      end
      2'b10: begin
        e.res = (a >= W) ? {W{d[W-1]}} : W'($signed(d) >>> a);
        e.c   = (a == 0) ? 1'b0 : (a <= W) ? d[a-1] : d[W-1];
      end
      default: begin
        dd    = {d, d} >> (a % W);
        e.res = dd[W-1:0];
        e.c   = (a == 0) ? 1'b0 : d[(a-1) % W];
      end
    endcase
    e.z   = (e.res == '0);
    e.amt = a;
    e.cyc = 0;
    return e;
  endfunction

  // Called at the negedge before the accept edge.
  task automatic push_exp(input logic [1:0] m, input int a, input logic [W-1:0] d);
    exp_t e;
    e     = model(m, a, d);
    e.cyc = cyc + 1 + a;
    exp_q.push_back(e);
  endtask

  // ---------------------------------------------------------------- monitor
  always @(negedge clk) begin
    if (reset_n) begin
      if (busy && done) chk("busy_done_overlap", 64'(busy & done), 64'd0);
      if (busy) busy_run++;
      if (done) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 64'd1, 64'd0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("result",   64'(result),    64'(mon_e.res));
          chk("carry",    64'(carry_out), 64'(mon_e.c));
          chk("overflow", 64'(overflow),  64'(mon_e.v));
          chk("zero",     64'(zero),      64'(mon_e.z));
          chk("done_cycle", 64'(cyc),     64'(mon_e.cyc));
          chk("busy_cycles", 64'(busy_run), 64'(mon_e.amt));
          last_e    = mon_e;
          have_last = 1;
        end
        busy_run = 0;
      end else if (!busy && have_last) begin
        chk("idle_hold_result", 64'(result), 64'(last_e.res));
        chk("idle_zero",        64'(zero),   64'(last_e.z));
      end
    end
  end

  // --------------------------------------------------------------- stimulus
  task automatic scramble();
    mode    = 2'($urandom);
    amount  = SW'($urandom);
    data_in = W'($urandom);
  endtask

  // Single operation; returns at the negedge of its done cycle.
  task automatic run_op(input logic [1:0] m, input int a, input logic [W-1:0] d, input bit inject);
    @(negedge clk);
    start = 1'b1; mode = m; amount = SW'(a); data_in = d;
    push_exp(m, a, d);
    @(negedge clk);
    start = 1'b0;
    scramble();
    if (inject && a >= 3) begin
      start = 1'b1;              // ignored while shifting
      @(negedge clk);
      start = 1'b0;
      repeat (a - 1) @(negedge clk);
    end else begin
      repeat (a) @(negedge clk);
    end
  endtask

  // Two operations with start held high; the second is taken at the edge
  // that ends the first one's DONE cycle.
  task automatic run_b2b(input logic [1:0] m1, input int a1, input logic [W-1:0] d1,
                         input logic [1:0] m2, input int a2, input logic [W-1:0] d2);
    @(negedge clk);
    start = 1'b1; mode = m1; amount = SW'(a1); data_in = d1;
    push_exp(m1, a1, d1);
    @(negedge clk);
    mode = m2; amount = SW'(a2); data_in = d2;
    repeat (a1) @(negedge clk);
    push_exp(m2, a2, d2);
    @(negedge clk);
    start = 1'b0;
    scramble();
    repeat (a2) @(negedge clk);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    // Asynchronous reset before any clock edge.
    #1 reset_n = 1'b0;
    #1;
    chk("rst_result", 64'(result),    64'd0);
    chk("rst_carry",  64'(carry_out), 64'd0);
    chk("rst_ovf",    64'(overflow),  64'd0);
    chk("rst_busy",   64'(busy),      64'd0);
    chk("rst_done",   64'(done),      64'd0);
    chk("rst_zero",   64'(zero),      64'd1);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // Directed cases.
    run_op(2'b00, 1,  16'h8001, 0);
    run_op(2'b10, 4,  16'h8000, 0);
    run_op(2'b01, 20, 16'hFFFF, 0);
    run_op(2'b11, 1,  16'h0001, 0);
    run_op(2'b11, 16, 16'h1234, 0);
    for (int m = 0; m < 4; m++) run_op(2'(m), 0, 16'hA5A5, 0);
    run_op(2'b10, 31, 16'h8421, 0);
    run_op(2'b11, 31, 16'h8421, 0);
    run_op(2'b00, 6,  16'h0300, 1);
    run_b2b(2'b01, 3, 16'hF0F0, 2'b00, 2, 16'h4001);
    run_b2b(2'b11, 0, 16'h0F0F, 2'b10, 5, 16'h9000);
    drain();

    // Reset in the middle of an LSL by 10.
    @(negedge clk);
    start = 1'b1; mode = 2'b00; amount = SW'(10); data_in = 16'h0F0F;
    push_exp(2'b00, 10, 16'h0F0F);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("midrst_result", 64'(result),    64'd0);
    chk("midrst_carry",  64'(carry_out), 64'd0);
    chk("midrst_ovf",    64'(overflow),  64'd0);
    chk("midrst_busy",   64'(busy),      64'd0);
    chk("midrst_done",   64'(done),      64'd0);
    chk("midrst_zero",   64'(zero),      64'd1);
    exp_q.delete();
    have_last = 0;
    busy_run  = 0;
    repeat (2) @(negedge clk);
    chk("rst_hold_busy", 64'(busy), 64'd0);
    reset_n = 1'b1;
    run_op(2'b00, 10, 16'h0F0F, 0);
    drain();

    // Randomised operations.
    for (int i = 0; i < 60; i++) begin
      int sel;
      sel = int'($urandom_range(0, 3));
      if (sel == 0) begin
        run_b2b(2'($urandom), int'($urandom_range(0, 31)), W'($urandom),
                2'($urandom), int'($urandom_range(0, 31)), W'($urandom));
      end else begin
        run_op(2'($urandom), int'($urandom_range(0, 31)), W'($urandom), sel == 1);
      end
      if ($urandom_range(0, 1) == 1) repeat (int'($urandom_range(1, 3))) @(negedge clk);
    end
    drain();
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
